// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data width, the NOP encoding and the fetch FSM states.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: synchronous FIFO with same-cycle head visibility and a
// flush that discards contents and any same-cycle push/pop.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    // The fetch credit scheme must make a push into a full buffer impossible.
    push_into_full_a: assert property (@(posedge clk) disable iff (rst)
        (push_i && !flush_i && full) |-> pop_i);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: credit-limited request issue, in-order response
// buffering, and redirect handling that drains stale in-flight responses.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output fetch_state_e    dbg_state_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   stale_q, stale_d;

    logic            grant;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [2*XLEN-1:0] fifo_rdata;
    logic [CW:0]     in_use;

    // Buffered plus in-flight entries never exceed DEPTH, so every response has a slot.
    assign in_use    = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign imem_req  = (state_q == ST_RUN) && (in_use < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc_q;
    assign grant     = imem_req && imem_gnt;

    assign out_valid   = !fifo_empty;
    assign out_instr   = fifo_empty ? NOP_INSTR : fifo_rdata[XLEN-1:0];
    assign out_pc      = fifo_empty ? resp_pc_q : fifo_rdata[2*XLEN-1:XLEN];
    assign fifo_pop    = out_valid && out_ready;
    assign dbg_state_o = state_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        stale_d       = stale_q;
        fifo_push     = 1'b0;
        outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid);

        if (redirect_valid) begin
            // A same-cycle grant becomes stale; a same-cycle response is dropped.
            fetch_pc_d = word_align(redirect_pc);
            resp_pc_d  = word_align(redirect_pc);
            stale_d    = outstanding_d;
        end else begin
            if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
            if (imem_rvalid) begin
                if (stale_q != '0) begin
                    stale_d = stale_q - 1'b1;
                end else begin
                    fifo_push = 1'b1;
                    resp_pc_d = resp_pc_q + 32'd4;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_RUN;
            ST_RUN:   if (redirect_valid && stale_d != '0) state_d = ST_DRAIN;
            ST_DRAIN: if (stale_d == '0) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            stale_q       <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            stale_q       <= stale_d;
        end
    end

    fetch_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_valid),
        .push_i  (fifo_push),
        .data_i  ({resp_pc_q, imem_rdata}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_rdata),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: in-order memory model plus an occupancy/PC-stream
// reference model, with directed scenarios and a randomized run.
module tb_instr_fetch;
    import cpu_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_gnt = 1'b0;
    logic         imem_rvalid = 1'b0;
    logic [31:0]  imem_rdata = '0;
    logic         redirect_valid = 1'b0;
    logic [31:0]  redirect_pc = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_instr;
    logic [31:0]  out_pc;
    fetch_state_e dbg_state;

    instr_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .dbg_state_o    (dbg_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: buffer occupancy, in-flight and stale counts, PC streams
    int          occ, outs, stale;
    bit          in_idle;
    logic [31:0] exp_fetch_pc, exp_out_pc;

    // memory model
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          cyc;
    int          lat_min = 1, lat_max = 1;
    bit          hold_resp = 1'b0;

    int          n_grants, n_pops;
    logic [31:0] grant_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    task automatic model_reset();
        occ = 0; outs = 0; stale = 0; in_idle = 1'b1;
        exp_fetch_pc = RESET_PC; exp_out_pc = RESET_PC;
        pend_addr.delete(); pend_due.delete(); grant_log.delete();
        n_grants = 0; n_pops = 0; cyc = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        hold_resp = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive inputs at the falling edge, check outputs, advance the model.
    task automatic drive_cycle(input bit gnt, input bit ready, input bit redir, input logic [31:0] tgt);
        bit           rv, exp_req, g, pop;
        fetch_state_e exp_st;
        logic [31:0]  tgt_al;
        rv = !hold_resp && pend_due.size() > 0 && pend_due[0] <= cyc;
        imem_gnt       = gnt;
        imem_rvalid    = rv;
        imem_rdata     = rv ? mem_word(pend_addr[0]) : $urandom();
        out_ready      = ready;
        redirect_valid = redir;
        redirect_pc    = tgt;
        #1;
        exp_req = !in_idle && stale == 0 && (occ + outs < DEPTH);
        exp_st  = in_idle ? ST_IDLE : (stale > 0 ? ST_DRAIN : ST_RUN);
        n_tests++;
        if (dbg_state !== exp_st) begin
            n_fail++; $display("FAIL state cyc %0d: got %0d expected %0d", cyc, dbg_state, exp_st);
        end
        n_tests++;
        if (imem_req !== exp_req) begin
            n_fail++; $display("FAIL imem_req cyc %0d: got %b expected %b", cyc, imem_req, exp_req);
        end
        n_tests++;
        if (out_valid !== (occ > 0)) begin
            n_fail++; $display("FAIL out_valid cyc %0d: got %b expected %b", cyc, out_valid, occ > 0);
        end
        if (exp_req) begin
            n_tests++;
            if (imem_addr !== exp_fetch_pc) begin
                n_fail++; $display("FAIL imem_addr cyc %0d: got %h expected %h", cyc, imem_addr, exp_fetch_pc);
            end
        end
        if (occ > 0) begin
            n_tests++;
            if (out_pc !== exp_out_pc || out_instr !== mem_word(exp_out_pc)) begin
                n_fail++;
                $display("FAIL out_head cyc %0d: got pc %h instr %h expected pc %h instr %h",
                         cyc, out_pc, out_instr, exp_out_pc, mem_word(exp_out_pc));
            end
        end
        if (imem_req && gnt) begin
            pend_addr.push_back(imem_addr);
            pend_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
            grant_log.push_back(imem_addr);
            n_grants++;
        end
        if (rv) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        g    = exp_req && gnt;
        pop  = occ > 0 && ready && !redir;
        outs = outs + int'(g) - int'(rv);
        if (redir) begin
            stale  = outs;
            occ    = 0;
            tgt_al = {tgt[31:2], 2'b00};
            exp_fetch_pc = tgt_al;
            exp_out_pc   = tgt_al;
        end else begin
            if (g) exp_fetch_pc = exp_fetch_pc + 32'd4;
            if (pop) begin
                occ--; exp_out_pc = exp_out_pc + 32'd4; n_pops++;
            end
            if (rv) begin
                if (stale > 0) stale--;
                else occ++;
            end
        end
        in_idle = 1'b0;
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_handshake: got req %b valid %b expected 0 0", imem_req, out_valid);
        end
        n_tests++;
        if (out_instr !== NOP_INSTR || out_pc !== RESET_PC) begin
            n_fail++; $display("FAIL reset_out: got instr %h pc %h expected %h %h", out_instr, out_pc, NOP_INSTR, RESET_PC);
        end
        n_tests++;
        if (dbg_state !== ST_IDLE) begin
            n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
        end
        do_reset();
    endtask

    task automatic test_stream();
        bit seen = 1'b0, gap = 1'b0;
        do_reset();
        lat_min = 1; lat_max = 1;
        repeat (20) begin
            if (out_valid) seen = 1'b1;
            else if (seen) gap = 1'b1;
            drive_cycle(1'b1, 1'b1, 1'b0, '0);
        end
        n_tests++;
        if (gap !== 1'b0 || n_pops < 16) begin
            n_fail++; $display("FAIL stream_rate: got gap %b pops %0d expected gap 0 pops >= 16", gap, n_pops);
        end
        n_tests++;
        if (grant_log[0] !== 32'h0 || grant_log[1] !== 32'h4 || grant_log[2] !== 32'h8) begin
            n_fail++; $display("FAIL stream_addrs: got %h %h %h expected 0 4 8", grant_log[0], grant_log[1], grant_log[2]);
        end
    endtask

    task automatic test_stall();
        do_reset();
        lat_min = 1; lat_max = 1;
        repeat (10) drive_cycle(1'b1, 1'b0, 1'b0, '0);
        n_tests++;
        if (n_grants !== DEPTH || imem_req !== 1'b0) begin
            n_fail++; $display("FAIL stall_credit: got grants %0d req %b expected %0d 0", n_grants, imem_req, DEPTH);
        end
        n_tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
            n_fail++; $display("FAIL stall_head: got valid %b pc %h expected 1 0", out_valid, out_pc);
        end
        repeat (DEPTH) drive_cycle(1'b1, 1'b1, 1'b0, '0);
        n_tests++;
        if (n_pops !== DEPTH) begin
            n_fail++; $display("FAIL stall_drain: got pops %0d expected %0d", n_pops, DEPTH);
        end
    endtask

    task automatic test_redirect_drain();
        bit found = 1'b0;
        do_reset();
        lat_min = 1; lat_max = 1;
        hold_resp = 1'b1;
        drive_cycle(1'b0, 1'b1, 1'b0, '0);
        repeat (2) drive_cycle(1'b1, 1'b1, 1'b0, '0);
        drive_cycle(1'b0, 1'b1, 1'b1, 32'h100);
        n_tests++;
        if (dbg_state !== ST_DRAIN || imem_req !== 1'b0) begin
            n_fail++; $display("FAIL drain_enter: got state %0d req %b expected %0d 0", dbg_state, imem_req, ST_DRAIN);
        end
        hold_resp = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (out_valid) found = 1'b1;
            else drive_cycle(1'b1, 1'b0, 1'b0, '0);
        end
        n_tests++;
        if (!found || out_pc !== 32'h100 || out_instr !== mem_word(32'h100)) begin
            n_fail++; $display("FAIL drain_first: got valid %b pc %h instr %h expected 1 100 %h",
                               found, out_pc, out_instr, mem_word(32'h100));
        end
        repeat (4) drive_cycle(1'b1, 1'b1, 1'b0, '0);
    endtask

    task automatic test_redirect_grant_pop();
        do_reset();
        lat_min = 1; lat_max = 1;
        repeat (3) drive_cycle(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 10 && outs != 0; i++) drive_cycle(1'b0, 1'b0, 1'b0, '0);
        n_tests++;
        if (imem_req !== 1'b1 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL gp_setup: got req %b valid %b expected 1 1", imem_req, out_valid);
        end
        drive_cycle(1'b1, 1'b1, 1'b1, 32'h203);
        n_tests++;
        if (out_valid !== 1'b0 || dbg_state !== ST_DRAIN) begin
            n_fail++; $display("FAIL gp_flush: got valid %b state %0d expected 0 %0d", out_valid, dbg_state, ST_DRAIN);
        end
        for (int i = 0; i < 10 && !imem_req; i++) drive_cycle(1'b0, 1'b1, 1'b0, '0);
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            n_fail++; $display("FAIL gp_next_addr: got req %b addr %h expected 1 200", imem_req, imem_addr);
        end
        repeat (6) drive_cycle(1'b1, 1'b1, 1'b0, '0);
    endtask

    task automatic test_wrap();
        do_reset();
        lat_min = 1; lat_max = 2;
        drive_cycle(1'b0, 1'b1, 1'b0, '0);
        drive_cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        grant_log.delete();
        repeat (8) drive_cycle(1'b1, 1'b1, 1'b0, '0);
        n_tests++;
        if (grant_log.size() < 2 || grant_log[0] !== 32'hFFFF_FFFC || grant_log[1] !== 32'h0) begin
            n_fail++; $display("FAIL wrap_addr: got %0d grants first %h second %h expected fffffffc 00000000",
                               grant_log.size(), grant_log.size() > 0 ? grant_log[0] : 32'hx,
                               grant_log.size() > 1 ? grant_log[1] : 32'hx);
        end
    endtask

    task automatic test_reset_in_drain();
        do_reset();
        lat_min = 1; lat_max = 1;
        hold_resp = 1'b1;
        drive_cycle(1'b0, 1'b1, 1'b0, '0);
        repeat (2) drive_cycle(1'b1, 1'b1, 1'b0, '0);
        drive_cycle(1'b0, 1'b1, 1'b1, 32'h40);
        n_tests++;
        if (dbg_state !== ST_DRAIN || out_pc !== 32'h40) begin
            n_fail++; $display("FAIL rd_setup: got state %0d pc %h expected %0d 40", dbg_state, out_pc, ST_DRAIN);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (dbg_state !== ST_IDLE || imem_req !== 1'b0 || out_valid !== 1'b0 ||
            out_instr !== NOP_INSTR || out_pc !== RESET_PC) begin
            n_fail++; $display("FAIL rd_async: got state %0d req %b valid %b instr %h pc %h expected %0d 0 0 %h %h",
                               dbg_state, imem_req, out_valid, out_instr, out_pc, ST_IDLE, NOP_INSTR, RESET_PC);
        end
        do_reset();
        repeat (4) drive_cycle(1'b1, 1'b1, 1'b0, '0);
        n_tests++;
        if (grant_log.size() == 0 || grant_log[0] !== RESET_PC) begin
            n_fail++; $display("FAIL rd_restart: got %0d grants first %h expected %h",
                               grant_log.size(), grant_log.size() > 0 ? grant_log[0] : 32'hx, RESET_PC);
        end
    endtask

    task automatic test_random();
        bit          g, r, d;
        logic [31:0] t;
        do_reset();
        lat_min = 1; lat_max = 3;
        repeat (1500) begin
            g = $urandom_range(0, 3) != 0;
            r = $urandom_range(0, 2) != 0;
            d = !in_idle && $urandom_range(0, 40) == 0;
            t = $urandom();
            drive_cycle(g, r, d, t);
        end
        n_tests++;
        if (n_pops < 100) begin
            n_fail++; $display("FAIL random_progress: got pops %0d expected >= 100", n_pops);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drain();
        test_redirect_grant_pop();
        test_wrap();
        test_reset_in_drain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
